// File: rtl/enemy_march_if.sv
// enemy_march_if: control/status bundle between game control and the march
// pacing timer.
//   master : drives enable, frame_tick, kill, wave_clear; observes outputs
//   slave  : the timer; observes the controls, drives mueva, march_phase,
//            speed_level and frame_cnt
interface enemy_march_if;
    logic       enable;
    logic       frame_tick;
    logic       kill;
    logic       wave_clear;
    logic       mueva;
    logic       march_phase;
    logic [3:0] speed_level;
    logic [7:0] frame_cnt;

    modport master (
        output enable, frame_tick, kill, wave_clear,
        input  mueva, march_phase, speed_level, frame_cnt
    );

    modport slave (
        input  enable, frame_tick, kill, wave_clear,
        output mueva, march_phase, speed_level, frame_cnt
    );
endinterface

// File: rtl/enemy_march_timer.sv
// enemy_march_timer: paces enemy formation stepping. Counts video frames and
// emits a one-cycle mueva strobe every "period" frames; the period shrinks as
// kills raise the speed level.
// Ports:
//   clk    : system clock
//   reset  : synchronous, active-high
//   bus    : enemy_march_if.slave
//            in  enable, frame_tick, kill, wave_clear
//            out mueva (move strobe), march_phase (toggles per move),
//                speed_level (0..MAX_LEVEL), frame_cnt (frames this period)
module enemy_march_timer #(
    parameter int BASE_FRAMES     = 30,
    parameter int STEP_FRAMES     = 3,
    parameter int MIN_FRAMES      = 4,
    parameter int KILLS_PER_LEVEL = 5,
    parameter int MAX_LEVEL       = 8
) (
    input  logic          clk,
    input  logic          reset,
    enemy_march_if.slave  bus
);
    localparam int KW = (KILLS_PER_LEVEL > 1) ? $clog2(KILLS_PER_LEVEL) : 1;

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PAUSE = 2'd2} state_t;

    state_t        state_q, state_d;
    logic          mueva_q, mueva_d;
    logic          phase_q, phase_d;
    logic [3:0]    level_q, level_d;
    logic [7:0]    cnt_q, cnt_d;
    logic [KW-1:0] kcnt_q, kcnt_d;

    int            raw;
    logic [7:0]    period;
    logic          tick_ok;
    logic          fire;

    // Period from the registered level; int arithmetic keeps raw from wrapping
    // when level*STEP exceeds BASE.
    always_comb begin
        raw    = BASE_FRAMES - int'(level_q) * STEP_FRAMES;
        period = (raw < MIN_FRAMES) ? 8'(MIN_FRAMES) : raw[7:0];
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (bus.wave_clear) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (bus.enable)  state_d = RUN;
                RUN:     if (!bus.enable) state_d = PAUSE;
                PAUSE:   if (bus.enable)  state_d = RUN;
                default: state_d = IDLE;
            endcase
        end
    end

    // Datapath next values. Ticks count only when the pre-edge state is RUN
    // and enable is still high; >= lets a period that shrank below the
    // current count fire on the next tick.
    always_comb begin
        tick_ok = (state_q == RUN) && bus.enable && bus.frame_tick;
        fire    = tick_ok && (cnt_q >= period - 8'd1);

        mueva_d = fire;
        phase_d = phase_q ^ fire;
        cnt_d   = cnt_q;
        if (tick_ok) cnt_d = fire ? 8'd0 : cnt_q + 8'd1;

        kcnt_d  = kcnt_q;
        level_d = level_q;
        if (bus.kill) begin
            if (kcnt_q == KW'(KILLS_PER_LEVEL - 1)) begin
                kcnt_d = '0;
                if (level_q < 4'(MAX_LEVEL)) level_d = level_q + 4'd1;
            end else begin
                kcnt_d = kcnt_q + KW'(1);
            end
        end

        // wave_clear restores initial speed and drops any pending fire or kill
        if (bus.wave_clear) begin
            mueva_d = 1'b0;
            phase_d = 1'b0;
            cnt_d   = '0;
            kcnt_d  = '0;
            level_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mueva_q <= 1'b0;
            phase_q <= 1'b0;
            cnt_q   <= '0;
            kcnt_q  <= '0;
            level_q <= '0;
        end else begin
            mueva_q <= mueva_d;
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
            kcnt_q  <= kcnt_d;
            level_q <= level_d;
        end
    end

    assign bus.mueva       = mueva_q;
    assign bus.march_phase = phase_q;
    assign bus.speed_level = level_q;
    assign bus.frame_cnt   = cnt_q;
endmodule

// File: tb/tb_enemy_march_timer.sv
// Bench for enemy_march_timer: vector table, hand sequences for the multi-cycle
// corner cases, then random stimulus against a kill-total based model.
module tb_enemy_march_timer;
    localparam int BASE = 30, STEP = 3, MINF = 4, KPL = 5, MAXL = 8;
    localparam bit O = 1'b0, I = 1'b1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    enemy_march_if bus();

    enemy_march_timer #(
        .BASE_FRAMES(BASE), .STEP_FRAMES(STEP), .MIN_FRAMES(MINF),
        .KILLS_PER_LEVEL(KPL), .MAX_LEVEL(MAXL)
    ) dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;
    int pulses = 0;     // cycles observed with mueva high
    bit last_fire;      // mueva right after the most recent tick edge

    // Reference model: level derived from total kills since last clear.
    int m_mode  = 0;    // 0 not started, 1 running, 2 paused
    int m_cnt   = 0;
    bit m_phase = 0;
    bit m_mueva = 0;
    int m_kills = 0;

    function automatic int exp_level();
        int l = m_kills / KPL;
        return (l > MAXL) ? MAXL : l;
    endfunction

    function automatic int pack(bit mv, bit ph, int lvl, int cnt);
        return (int'(mv) << 13) | (int'(ph) << 12) | ((lvl & 15) << 8) | (cnt & 255);
    endfunction

    function automatic int dut_pack();
        return pack(bus.mueva, bus.march_phase, int'(bus.speed_level), int'(bus.frame_cnt));
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        int per;
        if (rst || bus.wave_clear) begin
            m_mode = 0; m_cnt = 0; m_phase = 0; m_mueva = 0; m_kills = 0;
        end else begin
            per = BASE - exp_level() * STEP;
            if (per < MINF) per = MINF;
            m_mueva = 0;
            if (m_mode == 1 && bus.enable && bus.frame_tick) begin
                if (m_cnt + 1 >= per) begin
                    m_cnt = 0; m_mueva = 1; m_phase = !m_phase;
                end else begin
                    m_cnt++;
                end
            end
            if (m_mode != 1 && bus.enable)       m_mode = 1;
            else if (m_mode == 1 && !bus.enable) m_mode = 2;
            if (bus.kill) m_kills++;
        end
    endtask

    // One clock: model follows the same edge, outputs sampled 1 time unit later.
    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
        if (bus.mueva) pulses++;
        chk("model", dut_pack(), pack(m_mueva, m_phase, exp_level(), m_cnt));
    endtask

    task automatic idle_inputs();
        rst = 0; bus.frame_tick = 0; bus.kill = 0; bus.wave_clear = 0;
    endtask

    task automatic send_ticks(input int n, input int spacing);
        for (int i = 0; i < n; i++) begin
            bus.frame_tick = 1;
            cyc();
            last_fire = bus.mueva;
            bus.frame_tick = 0;
            for (int j = 1; j < spacing; j++) cyc();
        end
    endtask

    task automatic send_kills(input int n);
        for (int i = 0; i < n; i++) begin
            bus.kill = 1;
            cyc();
        end
        bus.kill = 0;
    endtask

    // Clear to initial speed and start running with frame_cnt = 0.
    task automatic restart();
        idle_inputs();
        bus.enable = 0; bus.wave_clear = 1; cyc();
        bus.wave_clear = 0; bus.enable = 1; cyc();
    endtask

    typedef struct {
        bit rst, en, tick, kill, wc;
        bit mv, ph;
        int lvl, cnt;
    } vec_t;
    vec_t tbl[16];

    int p0;

    initial begin
        bus.enable = 0; bus.frame_tick = 0; bus.kill = 0; bus.wave_clear = 0;

        //          rst en tick kill wc  mv ph lvl cnt
        tbl[0]  = '{I, O, O, O, O,  O, O, 0, 0};
        tbl[1]  = '{O, I, I, O, O,  O, O, 0, 0};  // IDLE->RUN, tick ignored
        tbl[2]  = '{O, I, I, O, O,  O, O, 0, 1};
        tbl[3]  = '{O, I, I, I, O,  O, O, 0, 2};
        tbl[4]  = '{O, I, O, I, O,  O, O, 0, 2};
        tbl[5]  = '{O, O, I, O, O,  O, O, 0, 2};  // RUN->PAUSE, tick ignored
        tbl[6]  = '{O, O, I, O, O,  O, O, 0, 2};
        tbl[7]  = '{O, I, I, O, O,  O, O, 0, 2};  // PAUSE->RUN, tick ignored
        tbl[8]  = '{O, I, I, O, O,  O, O, 0, 3};
        tbl[9]  = '{O, I, O, I, O,  O, O, 0, 3};
        tbl[10] = '{O, I, O, I, O,  O, O, 0, 3};
        tbl[11] = '{O, I, O, I, O,  O, O, 1, 3};  // fifth kill
        tbl[12] = '{O, I, I, I, I,  O, O, 0, 0};  // wave_clear drops kill and tick
        tbl[13] = '{O, I, I, O, O,  O, O, 0, 0};
        tbl[14] = '{O, I, I, O, O,  O, O, 0, 1};
        tbl[15] = '{I, I, I, O, O,  O, O, 0, 0};

        for (int i = 0; i < 16; i++) begin
            rst = tbl[i].rst; bus.enable = tbl[i].en; bus.frame_tick = tbl[i].tick;
            bus.kill = tbl[i].kill; bus.wave_clear = tbl[i].wc;
            cyc();
            chk($sformatf("vec%0d", i), dut_pack(),
                pack(tbl[i].mv, tbl[i].ph, tbl[i].lvl, tbl[i].cnt));
        end

        // Base period of 30 frames, then two more moves over 60 frames.
        restart();
        p0 = pulses;
        send_ticks(30, 10);
        chk("first_move_pulses", pulses - p0, 1);
        chk("first_move_phase", int'(bus.march_phase), 1);
        chk("first_move_cnt", int'(bus.frame_cnt), 0);
        send_ticks(60, 10);
        chk("next_moves_pulses", pulses - p0, 3);
        chk("next_moves_phase", int'(bus.march_phase), 1);

        // Speed-up: level 1 -> 27 frames, level 8 -> 6 frames, saturation.
        restart();
        send_kills(5);
        chk("lvl1", int'(bus.speed_level), 1);
        p0 = pulses;
        send_ticks(27, 2);
        chk("period27_pulses", pulses - p0, 1);
        chk("period27_last", int'(last_fire), 1);
        send_kills(35);
        chk("lvl8", int'(bus.speed_level), 8);
        send_kills(10);
        chk("lvl8_sat", int'(bus.speed_level), 8);
        p0 = pulses;
        send_ticks(6, 2);
        chk("period6_pulses", pulses - p0, 1);
        chk("period6_last", int'(last_fire), 1);

        // Period shrinks below the current count: fire on the next tick.
        restart();
        send_ticks(20, 2);
        send_kills(20);
        chk("shrink_lvl", int'(bus.speed_level), 4);
        send_ticks(1, 2);
        chk("shrink_fire", int'(last_fire), 1);
        chk("shrink_cnt", int'(bus.frame_cnt), 0);

        // Pause holds count and phase, resume continues.
        restart();
        send_ticks(10, 2);
        bus.enable = 0; cyc();
        send_ticks(5, 2);
        chk("pause_cnt", int'(bus.frame_cnt), 10);
        chk("pause_phase", int'(bus.march_phase), 0);
        bus.enable = 1; cyc();
        p0 = pulses;
        send_ticks(20, 2);
        chk("resume_pulses", pulses - p0, 1);
        chk("resume_last", int'(last_fire), 1);
        chk("resume_phase", int'(bus.march_phase), 1);

        // kill completing a level coincident with a tick uses the old period.
        restart();
        send_kills(4);
        send_ticks(26, 2);
        bus.kill = 1; bus.frame_tick = 1; cyc();
        bus.kill = 0; bus.frame_tick = 0;
        chk("coinc_state", dut_pack(), pack(0, 0, 1, 27));
        cyc();
        send_ticks(1, 2);
        chk("coinc_next_fire", int'(last_fire), 1);

        // wave_clear then reset mid-period at level 3, count 12.
        for (int k = 0; k < 2; k++) begin
            restart();
            send_kills(15);
            send_ticks(12, 2);
            chk("pre_clear", dut_pack(), pack(0, 0, 3, 12));
            bus.enable = 0;
            if (k == 0) bus.wave_clear = 1; else rst = 1;
            cyc();
            idle_inputs();
            chk(k == 0 ? "wave_clear_zero" : "reset_zero", dut_pack(), 0);
            send_ticks(3, 2);
            chk("idle_ignores_ticks", int'(bus.frame_cnt), 0);
            bus.enable = 1; cyc();
            send_ticks(1, 2);
            chk("rerun_count", int'(bus.frame_cnt), 1);
        end

        // Random stimulus against the model.
        rst = 1; cyc(); rst = 0;
        for (int i = 0; i < 4000; i++) begin
            rst            = ($urandom_range(299) == 0);
            bus.wave_clear = ($urandom_range(199) == 0);
            bus.enable     = ($urandom_range(9) != 0);
            bus.frame_tick = ($urandom_range(2) == 0);
            bus.kill       = ($urandom_range(5) == 0);
            cyc();
        end
        idle_inputs();
        cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
